oled_fb_writer: RTL
===================

# oled_fb_writer

Streams a full framebuffer from video RAM to the SSD1351 OLED after the init sequencer has finished. On `start`, it sends the window commands: set column (0x15), set row (0x75) and write RAM (0x5C). It then sends every framebuffer byte as data over the same 8-bit E-strobed bus the init sequencer uses. It sits downstream of the OLED init sequencer and reads the display port of the framebuffer dual-port RAM. An external mux selects the init sequencer's bus while `init_done`=0 and this block's bus afterwards.

## Interface
- `WIDTH`, 128, display columns, range 1..128
- `HEIGHT`, 128, display rows, range 1..128
- `BPP_BYTES`, 2, bytes per pixel (RGB565)
- `N` (derived), WIDTH*HEIGHT*BPP_BYTES, total pixel bytes; `ADDR_W` = clog2(N), minimum 1
- `clk`  in  1  system clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset (one clock domain)
- `init_done`  in  1  init sequencer finished; level signal
- `start`  in  1  request a full-frame refresh; sampled only in IDLE
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse at frame completion
- `fb_addr`  out  ADDR_W  framebuffer byte address (registered)
- `fb_data`  in  8  framebuffer byte; synchronous RAM, 1-cycle read latency
- `oled_cs`  out  1  chip select, active low
- `oled_e`  out  1  write strobe; the display latches on the falling edge
- `oled_dc`  out  1  0 = command, 1 = data/argument
- `oled_dout`  out  8  bus byte

## Operation
- States: IDLE, CMD_LOAD, CMD_LATCH, PIX_FETCH, PIX_LOAD, PIX_LATCH, FINISH.
- IDLE
  - If `start`=1 and `init_done`=1: `oled_cs`<=0, header index<=0, go to CMD_LOAD.
  - Otherwise stay in IDLE.
  - `start` outside IDLE, or with `init_done`=0, is ignored and not queued.
- Header is a fixed 7-byte sequence: 0x15, 0x00, WIDTH-1, 0x75, 0x00, HEIGHT-1, 0x5C. `dc`=0 for 0x15, 0x75 and 0x5C; `dc`=1 for the arguments.
- CMD_LOAD: `oled_dout`<=header[idx], `oled_dc`<=per byte, `oled_e`<=1, idx<=idx+1, go to CMD_LATCH.
- CMD_LATCH: `oled_e`<=0. If idx=7, go to PIX_FETCH with `fb_addr`<=0; else go to CMD_LOAD.
- PIX_FETCH: `fb_addr`=0 is presented to the RAM; go to PIX_LOAD.
- PIX_LOAD
  - `oled_dout`<=`fb_data`, `oled_dc`<=1, `oled_e`<=1.
  - If `fb_addr`=N-1, flag last; else `fb_addr`<=`fb_addr`+1.
  - Go to PIX_LATCH.
- PIX_LATCH: `oled_e`<=0; go to FINISH if last, else PIX_LOAD.
- FINISH: `done`=1 (decoded from state), `oled_cs`<=1, `oled_e`<=1, `oled_dc`<=0, `fb_addr`<=0; go to IDLE.
- The byte counter never wraps: `fb_addr` stops at N-1, so exactly N data bytes are sent per frame.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - state=IDLE, `oled_cs`=1, `oled_e`=1, `oled_dc`=0, `oled_dout`=0x00
  - `fb_addr`=0, `busy`=0, `done`=0
- Per bus byte: `oled_dout` and `oled_dc` change on the same edge that raises `oled_e`. `oled_e` is high 1 cycle, then low 1 cycle. Data is stable across the falling edge.
- The RAM samples `fb_addr` at a clock edge, and `fb_data` is valid the following cycle. `fb_addr` during PIX_FETCH or PIX_LATCH selects the byte consumed in the next PIX_LOAD.
- Cycle numbering, with `start` high in IDLE cycle 0:
  - Cycles 1–14: header; `oled_cs` low from cycle 1.
  - Cycle 15: PIX_FETCH.
  - Cycles 16..15+2N: pixel bytes.
  - Cycle 16+2N: FINISH, with `done`=1 and `busy`=1.
  - Cycle 17+2N: IDLE, with `oled_cs`=1.
- `start` held high continuously: a new frame starts in cycle 17+2N.
- Throughput: 2 cycles per byte; frame latency is 2N+17 cycles.
- `rst_n` asserted mid-frame: the bus returns to reset values at once and there is no `done` pulse. After release, the block waits for a new `start`.
- `init_done` falling mid-frame: ignored; the frame completes.

## Test plan
- Use WIDTH=4, HEIGHT=2, BPP_BYTES=2 (N=16), with RAM preloaded mem[i]=0xA0+i. Pulse `start` with `init_done`=1. Required response:
  - Bus bytes on `oled_e` falling edges: 15,00,03,75,00,01,5C then A0..AF.
  - `dc` sequence: 0,1,1,0,1,1,0 then sixteen 1s.
  - `done` high exactly in cycle 48; `busy` high in cycles 1–48.
- `start` with `init_done`=0 → no bus activity, `oled_cs` stays 1, `busy` stays 0.
- `start` re-pulsed in cycles 5 and 30 → ignored; exactly one frame of 23 bytes.
- `start` held high → back-to-back frames; the second 0x15 strobe begins in cycle 50, with `oled_cs` high for only cycle 49.
- `rst_n` low in cycle 20 (mid-pixel) → all outputs at reset values within the same cycle and no `done`. After release plus `start`, a full, correct 23-byte frame.
- Default params (N=32768) → exactly 32768 data strobes, last address 0x7FFF, and `done` at cycle 65552.

Source files
------------

// File: rtl/oled_fb_writer.sv
// Streams the SSD1351 window header (column, row, write-RAM) followed by every
// framebuffer byte over the 8-bit E-strobed bus, two clocks per bus byte.
module oled_fb_writer #(
  parameter int WIDTH     = 128,
  parameter int HEIGHT    = 128,
  parameter int BPP_BYTES = 2,
  localparam int N        = WIDTH * HEIGHT * BPP_BYTES,
  localparam int ADDR_W   = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              init_done,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_data,
  output logic              oled_cs,
  output logic              oled_e,
  output logic              oled_dc,
  output logic [7:0]        oled_dout
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [7:0]        COL_END   = 8'(WIDTH - 1);
  localparam logic [7:0]        ROW_END   = 8'(HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE, CMD_LOAD, CMD_LATCH, PIX_FETCH, PIX_LOAD, PIX_LATCH, FINISH
  } state_t;

  state_t     state;
  logic [2:0] idx;
  logic       last;
  logic [7:0] hdr_byte;
  logic       hdr_dc;

  // Window header: opcodes go out with dc=0, their arguments with dc=1.
  always_comb begin
    hdr_byte = 8'h00;
    hdr_dc   = 1'b1;
    case (idx)
      3'd0:    begin hdr_byte = 8'h15;   hdr_dc = 1'b0; end
      3'd1:    hdr_byte = 8'h00;
      3'd2:    hdr_byte = COL_END;
      3'd3:    begin hdr_byte = 8'h75;   hdr_dc = 1'b0; end
      3'd4:    hdr_byte = 8'h00;
      3'd5:    hdr_byte = ROW_END;
      default: begin hdr_byte = 8'h5C;   hdr_dc = 1'b0; end
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= 3'd0;
      last      <= 1'b0;
      fb_addr   <= '0;
      oled_cs   <= 1'b1;
      oled_e    <= 1'b1;
      oled_dc   <= 1'b0;
      oled_dout <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (start && init_done) begin
            oled_cs <= 1'b0;
            idx     <= 3'd0;
            state   <= CMD_LOAD;
          end
        end
        CMD_LOAD: begin
          oled_dout <= hdr_byte;
          oled_dc   <= hdr_dc;
          oled_e    <= 1'b1;
          idx       <= idx + 3'd1;
          state     <= CMD_LATCH;
        end
        CMD_LATCH: begin
          oled_e <= 1'b0;
          if (idx == 3'd7) begin
            fb_addr <= '0;
            last    <= 1'b0;
            state   <= PIX_FETCH;
          end else begin
            state <= CMD_LOAD;
          end
        end
        // Address 0 is on the RAM port this cycle; its data arrives in PIX_LOAD.
        PIX_FETCH: state <= PIX_LOAD;
        PIX_LOAD: begin
          oled_dout <= fb_data;
          oled_dc   <= 1'b1;
          oled_e    <= 1'b1;
          if (fb_addr == LAST_ADDR) last <= 1'b1;
          else                      fb_addr <= fb_addr + 1'b1;
          state <= PIX_LATCH;
        end
        PIX_LATCH: begin
          oled_e <= 1'b0;
          state  <= last ? FINISH : PIX_LOAD;
        end
        FINISH: begin
          oled_cs <= 1'b1;
          oled_e  <= 1'b1;
          oled_dc <= 1'b0;
          fb_addr <= '0;
          last    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
